fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
Control block that drives the fetch-stage control inputs of program_memory_block: stall, stall_pm, pc_mux_sel and jmp_loc.
- Arbitrates between EX-stage taken branches, ID-stage jumps, load-use hazards and an external hold.
- Sequences redirect, bubble and flush windows with a registered state machine.
- Sits between the decode/hazard logic and the fetch stage of the MIPS pipeline.

Parameters:
ADDR_W, 16, width of instruction addresses and jmp_loc
JUMP_OPC, 6'b000010, opcode field ins_id[31:26] that identifies an unconditional jump
STALL_CYCLES, 1, bubble length for a load-use hazard (legal range 1-7)
FLUSH_CYCLES, 2, cycles flush is held high after a redirect, counting from the redirect cycle itself (legal range 1-7)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
ins_id  input  32  instruction currently in the ID stage
branch_taken  input  1  EX stage resolved a taken branch this cycle
branch_target  input  ADDR_W  target address of that branch
load_use_hazard  input  1  ID instruction depends on a load in EX
ext_hold  input  1  external fetch hold (debug/memory busy)
stall  output  1  to fetch stage: hold the PC
stall_pm  output  1  to fetch stage: hold the instruction output
pc_mux_sel  output  1  to fetch stage: select jmp_loc as the next address
jmp_loc  output  ADDR_W  redirect address
flush  output  1  squash the instruction in the IF/ID registers
state  output  3  debug view of the FSM: RUN=0, STALL=1, HOLD=2, REDIRECT=3, FLUSH=4

Behaviour:
- All outputs are registered; each decision is visible the cycle after the inputs are sampled.
- Reset (reset=0, asynchronous):
  - state=RUN; stall, stall_pm, pc_mux_sel and flush = 0; jmp_loc = 0; internal counter = 0.
  - Reset release is synchronous to clk.
  - Reset asserted mid-redirect, mid-stall or mid-flush aborts the operation immediately, with no residual pulse.
- Request priority, evaluated at each posedge: branch_taken > jump (ins_id[31:26]==JUMP_OPC) > load_use_hazard > ext_hold.
- RUN: all outputs 0 except jmp_loc, which holds its last value.
  - branch_taken -> REDIRECT, jmp_loc <= branch_target.
  - else jump -> REDIRECT, jmp_loc <= ins_id[ADDR_W-1:0].
  - else load_use_hazard -> STALL, counter <= STALL_CYCLES-1.
  - else ext_hold -> HOLD.
- STALL: stall=stall_pm=1.
  - Counter decrements each cycle; at 0 -> RUN.
  - STALL_CYCLES=1 gives exactly one stall cycle.
  - branch_taken aborts to REDIRECT.
  - Jump decode is ignored because ID is frozen; it is re-evaluated in RUN.
- HOLD: stall=stall_pm=1 while in this state.
  - Exits to RUN on the posedge where ext_hold is sampled 0.
  - branch_taken aborts to REDIRECT.
- REDIRECT: exactly one cycle with pc_mux_sel=1, flush=1, stall=stall_pm=0.
  - If FLUSH_CYCLES>1 -> FLUSH with counter <= FLUSH_CYCLES-2; else -> RUN.
- FLUSH: flush=1, pc_mux_sel=0.
  - Counter decrements; at 0 -> RUN.
  - Jump and load_use_hazard are ignored, since the instruction is squashed.
  - ext_hold is ignored until RUN.
- Branch while in REDIRECT or FLUSH: the newest branch wins. Go to REDIRECT again with the new target and restart the flush count.
- ext_hold concurrent with branch: the branch is served first. HOLD is entered from RUN afterwards if ext_hold is still high.
- stall and pc_mux_sel are never 1 in the same cycle. flush is never 1 while stall=1.
- The counter width must hold 7; it never wraps, because it only loads on state entry.

Test Plan:
- Reset: hold reset=0 for 3 cycles with random inputs -> all outputs 0, state=0. Assert reset=0 mid-FLUSH -> flush drops in the same cycle, without waiting for clk.
- Load-use: STALL_CYCLES=2, pulse load_use_hazard for 1 cycle in RUN -> stall=stall_pm=1 for exactly 2 cycles starting the next cycle, then RUN.
- Branch: branch_taken=1, branch_target=16'h0040 -> next cycle pc_mux_sel=1, jmp_loc=16'h0040, flush=1; the following cycle flush=1, pc_mux_sel=0; then RUN (FLUSH_CYCLES=2).
- Jump decode: ins_id=32'h0800_0123 in RUN -> pc_mux_sel=1 with jmp_loc=16'h0123 one cycle later. Same instruction presented during STALL -> no redirect until RUN.
- Simultaneous events: branch_taken with target 16'h0010 together with load_use_hazard and ext_hold -> REDIRECT to 16'h0010. A second branch to 16'h0020 during FLUSH -> new REDIRECT, jmp_loc=16'h0020, flush extended.
- Ext hold: ext_hold high for 5 cycles -> stall high for 5 cycles (one cycle lag at entry and exit). A branch arriving in cycle 3 of the hold exits HOLD to REDIRECT immediately.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch-stage control sequencer: arbitrates branches, jumps, load-use hazards and
// external holds into stall, redirect and flush windows for the program memory block.
module fetch_sequencer #(
    parameter int          ADDR_W       = 16,
    parameter logic [5:0]  JUMP_OPC     = 6'b000010,
    parameter int          STALL_CYCLES = 1,
    parameter int          FLUSH_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ins_id,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              load_use_hazard,
    input  logic              ext_hold,
    output logic              stall,
    output logic              stall_pm,
    output logic              pc_mux_sel,
    output logic [ADDR_W-1:0] jmp_loc,
    output logic              flush,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_STALL    = 3'd1,
        ST_HOLD     = 3'd2,
        ST_REDIRECT = 3'd3,
        ST_FLUSH    = 3'd4
    } state_t;

    // The redirect cycle itself counts as the first flush cycle.
    localparam logic [2:0] STALL_LOAD = 3'(STALL_CYCLES - 1);
    localparam logic [2:0] FLUSH_LOAD = 3'((FLUSH_CYCLES > 1) ? (FLUSH_CYCLES - 2) : 0);
    localparam logic       HAS_FLUSH  = (FLUSH_CYCLES > 1) ? 1'b1 : 1'b0;

    state_t              state_r;
    state_t              next_state_s;
    logic [2:0]          cnt_r;
    logic [2:0]          next_cnt_s;
    logic [ADDR_W-1:0]   next_jmp_s;
    logic                is_jump_s;
    logic                unused_ins_bits_s;

    assign is_jump_s         = (ins_id[31:26] == JUMP_OPC);
    assign unused_ins_bits_s = ^ins_id[25:ADDR_W];
    assign state             = state_r;

    // Next-state, counter and redirect-address decode with fixed request priority.
    always_comb begin
        next_state_s = state_r;
        next_cnt_s   = cnt_r;
        next_jmp_s   = jmp_loc;
        if (branch_taken) begin
            next_state_s = ST_REDIRECT;
            next_jmp_s   = branch_target;
            next_cnt_s   = 3'd0;
        end else begin
            case (state_r)
                ST_RUN: begin
                    if (is_jump_s) begin
                        next_state_s = ST_REDIRECT;
                        next_jmp_s   = ins_id[ADDR_W-1:0];
                    end else if (load_use_hazard) begin
                        next_state_s = ST_STALL;
                        next_cnt_s   = STALL_LOAD;
                    end else if (ext_hold) begin
                        next_state_s = ST_HOLD;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_STALL: begin
                    if (cnt_r == 3'd0) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_cnt_s = cnt_r - 3'd1;
                    end
                end
                ST_HOLD: begin
                    if (!ext_hold) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_state_s = ST_HOLD;
                    end
                end
                ST_REDIRECT: begin
                    if (HAS_FLUSH) begin
                        next_state_s = ST_FLUSH;
                        next_cnt_s   = FLUSH_LOAD;
                    end else begin
                        next_state_s = ST_RUN;
                    end
                end
                ST_FLUSH: begin
                    if (cnt_r == 3'd0) begin
                        next_state_s = ST_RUN;
                    end else begin
                        next_cnt_s = cnt_r - 3'd1;
                    end
                end
                default: begin
                    next_state_s = ST_RUN;
                    next_cnt_s   = 3'd0;
                end
            endcase
        end
    end

    // State register with outputs registered from the decoded next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= ST_RUN;
            cnt_r      <= 3'd0;
            jmp_loc    <= {ADDR_W{1'b0}};
            stall      <= 1'b0;
            stall_pm   <= 1'b0;
            pc_mux_sel <= 1'b0;
            flush      <= 1'b0;
        end else begin
            state_r    <= next_state_s;
            cnt_r      <= next_cnt_s;
            jmp_loc    <= next_jmp_s;
            stall      <= (next_state_s == ST_STALL) || (next_state_s == ST_HOLD);
            stall_pm   <= (next_state_s == ST_STALL) || (next_state_s == ST_HOLD);
            pc_mux_sel <= (next_state_s == ST_REDIRECT);
            flush      <= (next_state_s == ST_REDIRECT) || (next_state_s == ST_FLUSH);
        end
    end

endmodule
